// File: rtl/pipe_cfg_pkg.sv
// rtl/pipe_cfg_pkg.sv - shared constants, state encoding and config type for the pipeline scheduler
package pipe_cfg_pkg;

  localparam int unsigned THRESH_W       = 22;
  localparam int unsigned THRESH_DEFAULT = 500000;

  typedef logic [1:0] state_t;

  localparam state_t IDLE     = 2'd0;
  localparam state_t WAIT_SOF = 2'd1;
  localparam state_t FLUSH    = 2'd2;
  localparam state_t SETTLE   = 2'd3;

  // Committed configuration as seen by the Gaussian/Sobel datapath
  typedef struct packed {
    logic                mode;
    logic                gaussian;
    logic                sobel;
    logic [THRESH_W-1:0] threshold;
  } cfg_t;

  // Filter enables are meaningless in passthrough, so they are masked by mode
  function automatic logic [2:0] effective_flags(input logic mode, input logic gaussian,
                                                 input logic sobel);
    return {mode, gaussian & mode, sobel & mode};
  endfunction

endpackage

// File: rtl/pipe_cfg_scheduler_if.sv
// rtl/pipe_cfg_scheduler_if.sv - request/commit/flush signal bundle for the pipeline scheduler
interface pipe_cfg_scheduler_if #(
  parameter int unsigned THRESH_W = 22
);
  logic                i_sof;
  logic                i_req_mode;
  logic                i_req_gaussian;
  logic                i_req_sobel;
  logic [THRESH_W-1:0] i_req_threshold;
  logic                i_flush_ack;
  logic                o_mode;
  logic                o_gaussian_enable;
  logic                o_sobel_enable;
  logic [THRESH_W-1:0] o_sobel_threshold;
  logic                o_pipe_flush;
  logic                o_busy;
  logic [7:0]          o_update_count;
  logic                o_timeout;

  // Board control / datapath side
  modport master (
    output i_sof, i_req_mode, i_req_gaussian, i_req_sobel, i_req_threshold, i_flush_ack,
    input  o_mode, o_gaussian_enable, o_sobel_enable, o_sobel_threshold,
           o_pipe_flush, o_busy, o_update_count, o_timeout
  );

  // Scheduler side
  modport slave (
    input  i_sof, i_req_mode, i_req_gaussian, i_req_sobel, i_req_threshold, i_flush_ack,
    output o_mode, o_gaussian_enable, o_sobel_enable, o_sobel_threshold,
           o_pipe_flush, o_busy, o_update_count, o_timeout
  );
endinterface

// File: rtl/pipe_sched_watchdog.sv
// rtl/pipe_sched_watchdog.sv - clearable cycle counter with terminal pulse at LIMIT cycles
module pipe_sched_watchdog #(
  parameter int unsigned LIMIT = 1000
) (
  input  logic i_sysclk,
  input  logic i_rstn,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expire
);
  localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam logic [CW-1:0] LAST = CW'((LIMIT == 0) ? 0 : LIMIT - 1);

  logic [CW-1:0] r_cnt;

  // Count running cycles, holding at the terminal value until cleared
  always_ff @(posedge i_sysclk) begin
    if (!i_rstn || i_clear) begin
      r_cnt <= '0;
    end else if (i_run && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_run && (r_cnt == LAST);

endmodule

// File: rtl/pipe_cfg_scheduler.sv
// rtl/pipe_cfg_scheduler.sv - frame-synchronous commit of pipeline settings; optional watchdog via PIPE_SCHED_TIMEOUT_EN
module pipe_cfg_scheduler #(
  parameter int unsigned THRESH_W       = pipe_cfg_pkg::THRESH_W,
  parameter int unsigned THRESH_DEFAULT = pipe_cfg_pkg::THRESH_DEFAULT,
  parameter int unsigned SETTLE_FRAMES  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
  input  logic                 i_sysclk,
  input  logic                 i_rstn,
  pipe_cfg_scheduler_if.slave  io_cfg
);
  import pipe_cfg_pkg::*;

  localparam logic [THRESH_W-1:0] THR_RST  = THRESH_W'(THRESH_DEFAULT);
  localparam logic [3:0]          SETTLE_N = 4'(SETTLE_FRAMES);

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_flags;
  logic [THRESH_W-1:0] r_thr;
  logic [2:0]          r_sh_flags;
  logic [THRESH_W-1:0] r_sh_thr;
  logic [7:0]          r_count;
  logic [3:0]          r_settle_cnt;

  logic [2:0]          w_eff_flags;
  logic [THRESH_W-1:0] w_eff_thr;
  logic                w_structural;
  logic                w_differs;
  logic                w_sof_go;
  logic                w_ack_go;
  logic                w_snap;
  logic                w_commit_eff;
  logic                w_commit_sh;

  assign w_eff_flags  = effective_flags(io_cfg.i_req_mode, io_cfg.i_req_gaussian,
                                        io_cfg.i_req_sobel);
  assign w_eff_thr    = io_cfg.i_req_threshold;
  assign w_structural = (w_eff_flags != r_flags);
  assign w_differs    = w_structural || (w_eff_thr != r_thr);

`ifdef PIPE_SCHED_TIMEOUT_EN
  logic w_wd_run;
  logic w_wd_expire;
  logic r_timeout;

  assign w_wd_run = (r_state == WAIT_SOF) || (r_state == FLUSH);

  pipe_sched_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_sysclk (i_sysclk),
    .i_rstn   (i_rstn),
    .i_clear  (w_next != r_state),
    .i_run    (w_wd_run),
    .o_expire (w_wd_expire)
  );

  // Sticky record that the watchdog forced progress at least once
  always_ff @(posedge i_sysclk) begin
    if (!i_rstn) begin
      r_timeout <= 1'b0;
    end else if (w_wd_expire) begin
      r_timeout <= 1'b1;
    end
  end

  assign w_sof_go         = io_cfg.i_sof | w_wd_expire;
  assign w_ack_go         = io_cfg.i_flush_ack | w_wd_expire;
  assign io_cfg.o_timeout = r_timeout;
`else
  logic w_unused_timeout_cfg;

  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign w_sof_go             = io_cfg.i_sof;
  assign w_ack_go             = io_cfg.i_flush_ack;
  assign io_cfg.o_timeout     = 1'b0;
`endif

  // State register
  always_ff @(posedge i_sysclk) begin
    if (!i_rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and commit/snapshot strobes
  always_comb begin
    w_next       = r_state;
    w_snap       = 1'b0;
    w_commit_eff = 1'b0;
    w_commit_sh  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_differs) begin
          w_snap = 1'b1;
          w_next = WAIT_SOF;
        end
      end
      WAIT_SOF: begin
        w_snap = 1'b1;
        if (!w_differs) begin
          w_next = IDLE;
        end else if (w_sof_go) begin
          if (w_structural) begin
            w_next = FLUSH;
          end else begin
            w_commit_eff = 1'b1;
            w_next       = IDLE;
          end
        end
      end
      FLUSH: begin
        if (w_ack_go) begin
          w_commit_sh = 1'b1;
          w_next      = (SETTLE_N == 4'd0) ? IDLE : SETTLE;
        end
      end
      SETTLE: begin
        if (io_cfg.i_sof && ((r_settle_cnt + 4'd1) == SETTLE_N)) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Status outputs decoded straight from the state register
  always_comb begin
    io_cfg.o_busy       = (r_state != IDLE);
    io_cfg.o_pipe_flush = (r_state == FLUSH);
  end

  // Shadow tracks the latest request until FLUSH freezes it
  always_ff @(posedge i_sysclk) begin
    if (!i_rstn) begin
      r_sh_flags <= 3'b000;
      r_sh_thr   <= THR_RST;
    end else if (w_snap) begin
      r_sh_flags <= w_eff_flags;
      r_sh_thr   <= w_eff_thr;
    end
  end

  // Atomic commit of all settings plus commit counter
  always_ff @(posedge i_sysclk) begin
    if (!i_rstn) begin
      r_flags <= 3'b000;
      r_thr   <= THR_RST;
      r_count <= 8'd0;
    end else if (w_commit_eff) begin
      r_flags <= w_eff_flags;
      r_thr   <= w_eff_thr;
      r_count <= r_count + 8'd1;
    end else if (w_commit_sh) begin
      r_flags <= r_sh_flags;
      r_thr   <= r_sh_thr;
      r_count <= r_count + 8'd1;
    end
  end

  // Frames seen since entering SETTLE; the SOF that lands with the ack is not counted
  always_ff @(posedge i_sysclk) begin
    if (!i_rstn || (r_state != SETTLE)) begin
      r_settle_cnt <= 4'd0;
    end else if (io_cfg.i_sof) begin
      r_settle_cnt <= r_settle_cnt + 4'd1;
    end
  end

  assign io_cfg.o_mode            = r_flags[2];
  assign io_cfg.o_gaussian_enable = r_flags[1];
  assign io_cfg.o_sobel_enable    = r_flags[0];
  assign io_cfg.o_sobel_threshold = r_thr;
  assign io_cfg.o_update_count    = r_count;

endmodule

// File: tb/tb_pipe_cfg_scheduler.sv
// tb/tb_pipe_cfg_scheduler.sv - directed self-checking bench for pipe_cfg_scheduler
module tb_pipe_cfg_scheduler;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_fail;

  pipe_cfg_scheduler_if #(.THRESH_W(22)) u_if ();

  pipe_cfg_scheduler #(
    .THRESH_W       (22),
    .THRESH_DEFAULT (500000),
    .SETTLE_FRAMES  (1),
    .TIMEOUT_CYCLES (1000)
  ) u_dut (
    .i_sysclk (clk),
    .i_rstn   (rstn),
    .io_cfg   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_sof();
    u_if.i_sof = 1'b1;
    step();
    u_if.i_sof = 1'b0;
  endtask

  task automatic pulse_ack();
    u_if.i_flush_ack = 1'b1;
    step();
    u_if.i_flush_ack = 1'b0;
  endtask

  initial begin
    logic seen;
    int   n;
    n_cmp  = 0;
    n_fail = 0;
    rstn   = 1'b0;
    u_if.i_sof           = 1'b0;
    u_if.i_req_mode      = 1'b0;
    u_if.i_req_gaussian  = 1'b0;
    u_if.i_req_sobel     = 1'b0;
    u_if.i_req_threshold = 22'd500000;
    u_if.i_flush_ack     = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_mode", u_if.o_mode, 0);
    chk("rst_gauss", u_if.o_gaussian_enable, 0);
    chk("rst_sobel", u_if.o_sobel_enable, 0);
    chk("rst_thr", u_if.o_sobel_threshold, 500000);
    chk("rst_flush", u_if.o_pipe_flush, 0);
    chk("rst_busy", u_if.o_busy, 0);
    chk("rst_count", u_if.o_update_count, 0);
    chk("rst_timeout", u_if.o_timeout, 0);
    rstn = 1'b1;
    step();
    chk("idle_busy", u_if.o_busy, 0);

    // Threshold-only change committed at SOF, no flush
    u_if.i_req_threshold = 22'd550000;
    step();
    chk("thr_busy_detect", u_if.o_busy, 1);
    seen = 1'b0;
    repeat (100) begin
      step();
      if (u_if.o_pipe_flush) seen = 1'b1;
    end
    chk("thr_hold_pre_sof", u_if.o_sobel_threshold, 500000);
    pulse_sof();
    chk("thr_commit", u_if.o_sobel_threshold, 550000);
    chk("thr_count", u_if.o_update_count, 1);
    chk("thr_no_flush_now", u_if.o_pipe_flush, 0);
    chk("thr_no_flush_ever", seen, 0);
    chk("thr_busy_done", u_if.o_busy, 0);

    // Structural change: passthrough -> processing with Gaussian
    u_if.i_req_mode     = 1'b1;
    u_if.i_req_gaussian = 1'b1;
    step();
    chk("st_busy", u_if.o_busy, 1);
    chk("st_mode_pre", u_if.o_mode, 0);
    chk("st_flush_pre", u_if.o_pipe_flush, 0);
    pulse_sof();
    chk("st_flush_rise", u_if.o_pipe_flush, 1);
    chk("st_mode_in_flush", u_if.o_mode, 0);
    seen = 1'b0;
    repeat (39) begin
      step();
      if (!u_if.o_pipe_flush) seen = 1'b1;
    end
    chk("st_flush_held", seen, 0);
    pulse_ack();
    chk("st_flush_fall", u_if.o_pipe_flush, 0);
    chk("st_mode", u_if.o_mode, 1);
    chk("st_gauss", u_if.o_gaussian_enable, 1);
    chk("st_sobel", u_if.o_sobel_enable, 0);
    chk("st_thr_kept", u_if.o_sobel_threshold, 550000);
    chk("st_count", u_if.o_update_count, 2);
    chk("st_settle_busy", u_if.o_busy, 1);
    repeat (5) step();
    chk("st_settle_hold", u_if.o_busy, 1);
    pulse_sof();
    chk("st_settle_done", u_if.o_busy, 0);

    // Back to passthrough; SOF coinciding with ack is not counted as a settle frame
    u_if.i_req_mode     = 1'b0;
    u_if.i_req_gaussian = 1'b0;
    step();
    pulse_sof();
    u_if.i_flush_ack = 1'b1;
    u_if.i_sof       = 1'b1;
    step();
    u_if.i_flush_ack = 1'b0;
    u_if.i_sof       = 1'b0;
    chk("pt_mode", u_if.o_mode, 0);
    chk("pt_gauss", u_if.o_gaussian_enable, 0);
    chk("pt_count", u_if.o_update_count, 3);
    chk("pt_sof_ack_not_counted", u_if.o_busy, 1);
    pulse_sof();
    chk("pt_settle_done", u_if.o_busy, 0);

    // Enables toggled while in passthrough do not change the effective request
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      u_if.i_req_sobel    = i[0];
      u_if.i_req_gaussian = i[1];
      step();
      if (u_if.o_busy) seen = 1'b1;
    end
    u_if.i_req_sobel    = 1'b0;
    u_if.i_req_gaussian = 1'b0;
    chk("pt_toggle_no_busy", seen, 0);
    chk("pt_toggle_count", u_if.o_update_count, 3);
    chk("pt_toggle_sobel", u_if.o_sobel_enable, 0);

    // Latest of several threshold requests wins, single commit
    u_if.i_req_threshold = 22'd510000;
    step();
    u_if.i_req_threshold = 22'd520000;
    step();
    u_if.i_req_threshold = 22'd530000;
    step();
    repeat (3) step();
    chk("multi_hold", u_if.o_sobel_threshold, 550000);
    pulse_sof();
    chk("multi_thr", u_if.o_sobel_threshold, 530000);
    chk("multi_count", u_if.o_update_count, 4);

    // SOF in the detection cycle is not consumed
    u_if.i_req_threshold = 22'd540000;
    u_if.i_sof           = 1'b1;
    step();
    u_if.i_sof = 1'b0;
    chk("sof_idle_thr", u_if.o_sobel_threshold, 530000);
    chk("sof_idle_busy", u_if.o_busy, 1);
    repeat (2) step();
    pulse_sof();
    chk("sof_next_thr", u_if.o_sobel_threshold, 540000);
    chk("sof_next_count", u_if.o_update_count, 5);

    // Ack ignored in WAIT_SOF, then reset in the middle of FLUSH
    u_if.i_req_mode  = 1'b1;
    u_if.i_req_sobel = 1'b1;
    step();
    pulse_ack();
    chk("ack_wait_flush", u_if.o_pipe_flush, 0);
    chk("ack_wait_mode", u_if.o_mode, 0);
    chk("ack_wait_busy", u_if.o_busy, 1);
    pulse_sof();
    chk("rf_flush_up", u_if.o_pipe_flush, 1);
    rstn = 1'b0;
    step();
    chk("rf_flush", u_if.o_pipe_flush, 0);
    chk("rf_mode", u_if.o_mode, 0);
    chk("rf_sobel", u_if.o_sobel_enable, 0);
    chk("rf_thr", u_if.o_sobel_threshold, 500000);
    chk("rf_count", u_if.o_update_count, 0);
    chk("rf_busy", u_if.o_busy, 0);
    chk("rf_timeout", u_if.o_timeout, 0);
    u_if.i_req_mode      = 1'b0;
    u_if.i_req_sobel     = 1'b0;
    u_if.i_req_threshold = 22'd500000;
    rstn = 1'b1;
    repeat (2) step();
    chk("rf_idle_after", u_if.o_busy, 0);

`ifdef PIPE_SCHED_TIMEOUT_EN
    // Watchdog stands in for a missing flush ack after 1000 cycles
    u_if.i_req_mode = 1'b1;
    step();
    pulse_sof();
    chk("wd_flush_up", u_if.o_pipe_flush, 1);
    n = 0;
    while (!u_if.o_mode && n < 2000) begin
      step();
      n++;
    end
    chk("wd_cycles", n, 1000);
    chk("wd_timeout", u_if.o_timeout, 1);
    chk("wd_flush_down", u_if.o_pipe_flush, 0);
    chk("wd_count", u_if.o_update_count, 1);
`else
    n = 0;
    chk("nowd_timeout", u_if.o_timeout, n);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_cfg_scheduler.md
# pipe_cfg_scheduler

Frame-synchronous scheduler for committing video-pipeline settings: mode, filter enables and Sobel threshold. It sits between the board-input control logic and the Gaussian/Sobel datapath. Requested settings are applied only at start-of-frame. Structural changes are sequenced through a pipeline flush handshake and a settle period, so the datapath never switches configuration mid-frame.

## Interface
- THRESH_W, 22, width of Sobel threshold
- THRESH_DEFAULT, 500000, reset value of committed threshold
- SETTLE_FRAMES, 1, whole frames to hold busy after a flush commit (0..15)
- TIMEOUT_CYCLES, 2_500_000, watchdog limit in i_sysclk cycles (100 ms @ 25 MHz); used only with the macro
- Clock and reset: clock i_sysclk; reset i_rstn, synchronous, active-low.
- i_sysclk  in  1  system clock
- i_rstn  in  1  synchronous active-low reset
- i_sof  in  1  start-of-frame, one-cycle pulse, i_sysclk domain
- i_req_mode  in  1  requested mode (0 = passthrough)
- i_req_gaussian  in  1  requested Gaussian enable
- i_req_sobel  in  1  requested Sobel enable
- i_req_threshold  in  THRESH_W  requested Sobel threshold
- i_flush_ack  in  1  one-cycle pulse from datapath: line buffers drained
- o_mode  out  1  committed mode
- o_gaussian_enable  out  1  committed Gaussian enable
- o_sobel_enable  out  1  committed Sobel enable
- o_sobel_threshold  out  THRESH_W  committed threshold
- o_pipe_flush  out  1  flush request level
- o_busy  out  1  high whenever state != IDLE
- o_update_count  out  8  number of commits, wraps 255→0
- o_timeout  out  1  sticky watchdog flag

## Operation
- Effective request:
  - mode = i_req_mode
  - gaussian = i_req_gaussian & i_req_mode
  - sobel = i_req_sobel & i_req_mode
  - threshold = i_req_threshold
- Structural change: effective {mode, gaussian, sobel} differs from the committed values. A change in threshold alone is non-structural.
- IDLE:
  - If the effective request differs from committed, snapshot it into the shadow register and go to WAIT_SOF.
  - An i_sof in the same cycle is not consumed.
- WAIT_SOF:
  - The shadow re-snapshots every cycle (latest request wins).
  - If the request returns equal to committed, go to IDLE with no commit.
  - On i_sof with a structural shadow: set o_pipe_flush=1 and go to FLUSH.
  - On i_sof with a non-structural shadow: commit, increment o_update_count, go to IDLE.
  - i_flush_ack is ignored in this state.
- FLUSH:
  - o_pipe_flush is held at 1 and the shadow is frozen.
  - On i_flush_ack: commit, increment count, clear o_pipe_flush.
  - Then go to SETTLE, or to IDLE if SETTLE_FRAMES=0.
- SETTLE:
  - Count i_sof pulses (4-bit).
  - At the SETTLE_FRAMES-th pulse, go to IDLE.
  - An i_sof coinciding with the ack in FLUSH is not counted.
- Requests arriving in FLUSH or SETTLE are not lost. They are re-detected on return to IDLE.
- Commit updates all four committed outputs atomically on one edge.

## Timing
- Reset values:
  - o_mode=0, enables=0, o_sobel_threshold=THRESH_DEFAULT
  - o_pipe_flush=0, o_busy=0, o_update_count=0, o_timeout=0
  - state=IDLE
- Reset mid-operation drops o_pipe_flush at the next edge and discards the shadow.
- All outputs are registered. o_busy is decoded from the state register and asserts the cycle after the change is detected.
- Non-structural commit: outputs change on the edge sampling i_sof; visible the next cycle.
- Structural change: o_pipe_flush rises on the edge sampling i_sof. Committed outputs change and o_pipe_flush falls on the edge sampling i_flush_ack.
- Minimum structural sequence: detect (1) + wait SOF + ack wait + SETTLE_FRAMES frames.

## Configuration
- Macro PIPE_SCHED_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT_SOF and FLUSH, cleared on every state change.
  - When it reaches TIMEOUT_CYCLES, WAIT_SOF acts as if i_sof arrived and FLUSH acts as if i_flush_ack arrived.
  - o_timeout is set and stays set until reset.
- Macro undefined:
  - No counter.
  - o_timeout is tied 0.
  - The block waits indefinitely for i_sof or i_flush_ack.

## Structure
- Package pipe_cfg_pkg:
  - state encoding localparams (IDLE, WAIT_SOF, FLUSH, SETTLE)
  - THRESH_W and THRESH_DEFAULT constants
  - a packed config typedef {mode, gaussian, sobel, threshold} shared with the datapath
- One sub-module, pipe_sched_watchdog: load/clear counter with a terminal pulse. It is instantiated only under PIPE_SCHED_TIMEOUT_EN.

## Test plan
- Reset, then threshold request 550000, then i_sof after 100 cycles: threshold=550000 the cycle after SOF, o_pipe_flush never 1, count=1.
- Mode 0→1 with gaussian=1, i_sof, ack 40 cycles later, SETTLE_FRAMES=1: flush high exactly from SOF edge to ack edge; mode=1 and gaussian=1 at ack; busy clears at next SOF.
- In passthrough, toggle i_req_sobel: no state change and no commit (effective request is unchanged).
- Threshold changed 3 times before SOF (510000, 520000, 530000): a single commit of 530000, count=1.
- i_rstn asserted mid-FLUSH: o_pipe_flush=0 next cycle and all outputs at reset values; with PIPE_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=1000, no ack: commit at cycle 1000 of FLUSH and o_timeout=1.
